// File: rtl/matrix_product_checker_if.sv
// Handshake and matrix bus between a matrix_product_checker and its driver.
interface matrix_product_checker_if #(
    parameter int N = 5,
    parameter int W = 32
) ();
    logic             start;
    logic [N*N*W-1:0] a_flat;
    logic [N*N*W-1:0] b_flat;
    logic             busy;
    logic             done;
    logic [N*N*W-1:0] c_flat;
    logic             is_identity;
    logic             overflow;

    modport master (
        output start, a_flat, b_flat,
        input  busy, done, c_flat, is_identity, overflow
    );

    modport slave (
        input  start, a_flat, b_flat,
        output busy, done, c_flat, is_identity, overflow
    );
endinterface

// File: rtl/matrix_product_checker.sv
// Single-MAC sequential C = A x B with identity-within-tolerance check.
// Build option MATRIX_CHK_SAT_EN: saturate out-of-range elements instead of wrapping.
module matrix_product_checker #(
    parameter int N    = 5,
    parameter int W    = 32,
    parameter int FRAC = 0,
    parameter int TOL  = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    matrix_product_checker_if.slave bus
);
    localparam int IW    = (N > 1) ? $clog2(N) : 1;
    localparam int ACC_W = 2 * W + $clog2(N);
    localparam int MW    = N * N * W;
    localparam logic [IW-1:0] LAST = IW'(N - 1);
    localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_V = ~MAX_V;
    localparam logic [W-1:0] SAT_HI = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SAT_LO = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] ONE_V  = {{(W-1){1'b0}}, 1'b1} << FRAC;
    localparam logic [W:0]   TOL_V  = (W+1)'(TOL);

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_WRITE, S_DONE} state_t;

    state_t                   state_r, state_nx_s;
    logic [MW-1:0]            a_r, b_r, c_r;
    logic signed [ACC_W-1:0]  acc_r, shifted_s;
    logic [IW-1:0]            r_r, c_idx_r, k_r;
    logic                     busy_r, done_r, ident_r, ovf_r;
    logic                     busy_nx_s, done_nx_s;
    logic signed [W-1:0]      a_el_s, b_el_s;
    logic signed [2*W-1:0]    prod_s;
    logic                     in_range_s;
    logic [W-1:0]             store_s, expect_s;
    logic signed [W:0]        diff_s;
    logic [W:0]               diff_abs_s;
    logic                     ident_ok_s;

    // Next-state logic and the registered-output targets
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            S_IDLE:  if (bus.start) state_nx_s = S_MAC;
                     else           state_nx_s = S_IDLE;
            S_MAC:   if (k_r == LAST) state_nx_s = S_WRITE;
                     else             state_nx_s = S_MAC;
            S_WRITE: if ((r_r == LAST) && (c_idx_r == LAST)) state_nx_s = S_DONE;
                     else                                    state_nx_s = S_MAC;
            S_DONE:  state_nx_s = S_IDLE;
            default: state_nx_s = S_IDLE;
        endcase
        busy_nx_s = (state_nx_s == S_MAC) || (state_nx_s == S_WRITE);
        done_nx_s = (state_nx_s == S_DONE);
    end

    // Operand selection, product, scaling and the per-element identity test
    always_comb begin
        a_el_s     = a_r[(int'(r_r) * N + int'(k_r)) * W +: W];
        b_el_s     = b_r[(int'(k_r) * N + int'(c_idx_r)) * W +: W];
        prod_s     = a_el_s * b_el_s;
        shifted_s  = acc_r >>> FRAC;
        in_range_s = (shifted_s <= MAX_V) && (shifted_s >= MIN_V);
        if (in_range_s) begin
            store_s = shifted_s[W-1:0];
        end else begin
`ifdef MATRIX_CHK_SAT_EN
            store_s = shifted_s[ACC_W-1] ? SAT_LO : SAT_HI;
`else
            store_s = shifted_s[W-1:0];
`endif
        end
        expect_s   = (r_r == c_idx_r) ? ONE_V : {W{1'b0}};
        // One extra bit so the difference of two W-bit values cannot wrap
        diff_s     = {store_s[W-1], store_s} - {expect_s[W-1], expect_s};
        diff_abs_s = diff_s[W] ? $unsigned(-diff_s) : $unsigned(diff_s);
        ident_ok_s = (diff_abs_s <= TOL_V);
    end

    // State and handshake output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            busy_r  <= busy_nx_s;
            done_r  <= done_nx_s;
        end
    end

    // Datapath: operand capture, accumulation and element write-back
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_r     <= {MW{1'b0}};
            b_r     <= {MW{1'b0}};
            c_r     <= {MW{1'b0}};
            acc_r   <= {ACC_W{1'b0}};
            r_r     <= {IW{1'b0}};
            c_idx_r <= {IW{1'b0}};
            k_r     <= {IW{1'b0}};
            ident_r <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (bus.start) begin
                        a_r     <= bus.a_flat;
                        b_r     <= bus.b_flat;
                        c_r     <= {MW{1'b0}};
                        acc_r   <= {ACC_W{1'b0}};
                        r_r     <= {IW{1'b0}};
                        c_idx_r <= {IW{1'b0}};
                        k_r     <= {IW{1'b0}};
                        ident_r <= 1'b1;
                        ovf_r   <= 1'b0;
                    end else begin
                        acc_r <= acc_r;
                    end
                end
                S_MAC: begin
                    acc_r <= acc_r + ACC_W'(prod_s);
                    if (k_r == LAST) k_r <= {IW{1'b0}};
                    else             k_r <= k_r + 1'b1;
                end
                S_WRITE: begin
                    c_r[(int'(r_r) * N + int'(c_idx_r)) * W +: W] <= store_s;
                    if (!in_range_s) ovf_r   <= 1'b1;
                    if (!ident_ok_s) ident_r <= 1'b0;
                    if (c_idx_r == LAST) begin
                        c_idx_r <= {IW{1'b0}};
                        r_r     <= r_r + 1'b1;
                    end else begin
                        c_idx_r <= c_idx_r + 1'b1;
                    end
                    k_r   <= {IW{1'b0}};
                    acc_r <= {ACC_W{1'b0}};
                end
                S_DONE: begin
                    acc_r <= {ACC_W{1'b0}};
                end
                default: begin
                    acc_r <= {ACC_W{1'b0}};
                end
            endcase
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.c_flat      = c_r;
    assign bus.is_identity = ident_r;
    assign bus.overflow    = ovf_r;
endmodule

// File: tb/tb_matrix_product_checker.sv
// Scoreboard bench for matrix_product_checker: integer instance plus a Q16.16 tolerance instance.
module tb_matrix_product_checker;
    localparam int N  = 5;
    localparam int W  = 32;
    localparam int MW = N * N * W;

    typedef logic [MW-1:0] mat_t;
    typedef struct {
        mat_t c;
        logic id;
        logic ovf;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    matrix_product_checker_if #(.N(N), .W(W)) bus0 ();
    matrix_product_checker_if #(.N(N), .W(W)) bus1 ();

    matrix_product_checker #(.N(N), .W(W), .FRAC(0), .TOL(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0)
    );
    matrix_product_checker #(.N(N), .W(W), .FRAC(16), .TOL(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );

    exp_t sb0[$];
    exp_t sb1[$];
    int   errors = 0;
    int   checks = 0;

    int a_rows [N][N] = '{'{1,1,1,1,1}, '{2,3,2,2,2}, '{3,3,4,3,3}, '{4,4,4,5,4}, '{5,5,5,5,6}};
    int b_rows [N][N] = '{'{15,-1,-1,-1,-1}, '{-2,1,0,0,0}, '{-3,0,1,0,0}, '{-4,0,0,1,0}, '{-5,0,0,0,1}};

    function automatic mat_t from_rows(input int m [N][N]);
        mat_t res = '0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                res[(r*N+c)*W +: W] = W'(m[r][c]);
        return res;
    endfunction

    function automatic mat_t ident(input logic [W-1:0] one);
        mat_t res = '0;
        for (int i = 0; i < N; i++) res[(i*N+i)*W +: W] = one;
        return res;
    endfunction

    // Reference model: wide exact sums, then scale, range-check and compare to identity
    function automatic exp_t model(input mat_t a, input mat_t b, input int frac, input int tol);
        exp_t res;
        logic signed [2*W+3:0] acc, prod, sh;
        logic signed [W-1:0]   ae, be, st;
        longint maxl, minl, e, d;
        maxl    = (longint'(1) << (W-1)) - 1;
        minl    = -maxl - 1;
        res.c   = '0;
        res.id  = 1'b1;
        res.ovf = 1'b0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                acc = '0;
                for (int k = 0; k < N; k++) begin
                    ae   = a[(r*N+k)*W +: W];
                    be   = b[(k*N+c)*W +: W];
                    prod = ae * be;
                    acc  = acc + prod;
                end
                sh = acc >>> frac;
                st = sh[W-1:0];
                if (sh > maxl || sh < minl) begin
                    res.ovf = 1'b1;
`ifdef MATRIX_CHK_SAT_EN
                    st = (sh > maxl) ? maxl[W-1:0] : minl[W-1:0];
`endif
                end
                e = (r == c) ? (longint'(1) << frac) : 64'sd0;
                d = longint'(st) - e;
                if (d < 0) d = -d;
                if (d > tol) res.id = 1'b0;
                res.c[(r*N+c)*W +: W] = st;
            end
        end
        return res;
    endfunction

    task automatic pulse_start0(input mat_t a, input mat_t b, input bit push);
        @(negedge clk);
        @(negedge clk);
        bus0.a_flat = a;
        bus0.b_flat = b;
        bus0.start  = 1'b1;
        if (push) sb0.push_back(model(a, b, 0, 0));
        @(negedge clk);
        bus0.start = 1'b0;
    endtask

    // Counts edges after the start edge; optionally pokes start or asserts reset mid-run
    task automatic wait_done0(input int poke_at, input int rst_at, output int done_edge, output bit busy_bad);
        done_edge = -1;
        busy_bad  = 1'b0;
        for (int e = 1; e <= 200; e++) begin
            @(posedge clk);
            #1;
            if (bus0.done === 1'b1 && done_edge < 0) done_edge = e;
            if (done_edge < 0 && rst_at < 0 && bus0.busy !== 1'b1) busy_bad = 1'b1;
            if (e == poke_at) begin
                bus0.start  = 1'b1;
                bus0.a_flat = '0;
                bus0.b_flat = '0;
            end
            if (poke_at > 0 && e == poke_at + 1) bus0.start = 1'b0;
            if (rst_at > 0 && e == rst_at) rst_n = 1'b0;
            if (rst_at > 0 && e == rst_at + 2) rst_n = 1'b1;
            if (done_edge > 0 && rst_at < 0) break;
        end
    endtask

    task automatic check_result0(input string name);
        exp_t ex;
        checks++;
        if (sb0.size() == 0) begin
            errors++;
            $display("FAIL %s_sb: scoreboard empty, got c_flat=%h", name, bus0.c_flat);
        end else begin
            ex = sb0.pop_front();
            if (bus0.c_flat !== ex.c) begin
                errors++;
                $display("FAIL %s_c: got %h want %h", name, bus0.c_flat, ex.c);
            end
            checks++;
            if (bus0.is_identity !== ex.id) begin
                errors++;
                $display("FAIL %s_id: got %b want %b", name, bus0.is_identity, ex.id);
            end
            checks++;
            if (bus0.overflow !== ex.ovf) begin
                errors++;
                $display("FAIL %s_ovf: got %b want %b", name, bus0.overflow, ex.ovf);
            end
        end
    endtask

    task automatic timing_checks(input string name, input int de, input bit bb);
        checks++;
        if (de != 150) begin
            errors++;
            $display("FAIL %s_latency: done at edge %0d want 150", name, de);
        end
        checks++;
        if (bb) begin
            errors++;
            $display("FAIL %s_busy: busy dropped before done, want 1 throughout", name);
        end
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        bus0.start  = 1'b1;
        bus1.start  = 1'b0;
        bus0.a_flat = from_rows(a_rows);
        bus0.b_flat = from_rows(b_rows);
        bus1.a_flat = '0;
        bus1.b_flat = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (bus0.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", bus0.busy); end
        checks++; if (bus0.done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", bus0.done); end
        checks++; if (bus0.c_flat !== '0) begin errors++; $display("FAIL rst_c: got %h want 0", bus0.c_flat); end
        checks++; if (bus0.is_identity !== 1'b0) begin errors++; $display("FAIL rst_id: got %b want 0", bus0.is_identity); end
        checks++; if (bus0.overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b want 0", bus0.overflow); end
        bus0.start = 1'b0;
        rst_n      = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus0.busy !== 1'b0) begin errors++; $display("FAIL rst_start_wins: busy=%b want 0", bus0.busy); end
    endtask

    task automatic test_identity();
        int de; bit bb;
        pulse_start0(from_rows(a_rows), from_rows(b_rows), 1'b1);
        wait_done0(-1, -1, de, bb);
        timing_checks("ident", de, bb);
        check_result0("ident");
        checks++; if (bus0.c_flat !== ident(32'h0000_0001)) begin errors++; $display("FAIL ident_const_c: got %h", bus0.c_flat); end
        checks++; if (bus0.is_identity !== 1'b1) begin errors++; $display("FAIL ident_const_id: got %b want 1", bus0.is_identity); end
    endtask

    task automatic test_mul_identity();
        int de; bit bb;
        pulse_start0(from_rows(a_rows), ident(32'h0000_0001), 1'b1);
        wait_done0(-1, -1, de, bb);
        timing_checks("muli", de, bb);
        check_result0("muli");
        checks++; if (bus0.c_flat !== from_rows(a_rows)) begin errors++; $display("FAIL muli_eq_a: got %h", bus0.c_flat); end
        checks++; if (bus0.is_identity !== 1'b0) begin errors++; $display("FAIL muli_id: got %b want 0", bus0.is_identity); end
    endtask

    task automatic test_overflow();
        int de; bit bb;
        mat_t a = '0;
        logic [W-1:0] want;
        a[W-1:0] = 32'h7FFF_FFFF;
`ifdef MATRIX_CHK_SAT_EN
        want = 32'h7FFF_FFFF;
`else
        want = 32'h0000_0001;
`endif
        pulse_start0(a, a, 1'b1);
        wait_done0(-1, -1, de, bb);
        timing_checks("ovf", de, bb);
        check_result0("ovf");
        checks++; if (bus0.c_flat[W-1:0] !== want) begin errors++; $display("FAIL ovf_c00: got %h want %h", bus0.c_flat[W-1:0], want); end
        checks++; if (bus0.overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", bus0.overflow); end
    endtask

    task automatic test_ignored_start_and_reset();
        int de; bit bb;
        pulse_start0(from_rows(a_rows), from_rows(b_rows), 1'b1);
        wait_done0(10, -1, de, bb);
        timing_checks("restart", de, bb);
        check_result0("restart");
        pulse_start0(from_rows(a_rows), from_rows(b_rows), 1'b0);
        wait_done0(-1, 40, de, bb);
        checks++; if (de != -1) begin errors++; $display("FAIL midrst_done: done at edge %0d want none", de); end
        checks++; if (bus0.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", bus0.busy); end
        checks++; if (bus0.c_flat !== '0) begin errors++; $display("FAIL midrst_c: got %h want 0", bus0.c_flat); end
    endtask

    task automatic run_tol(input logic [W-1:0] b44, input logic want_id, input string name);
        mat_t a, b;
        exp_t ex;
        int   de = -1;
        a = ident(32'h0001_0000);
        b = ident(32'h0001_0000);
        b[24*W +: W] = b44;
        sb1.push_back(model(a, b, 16, 2));
        @(negedge clk);
        @(negedge clk);
        bus1.a_flat = a;
        bus1.b_flat = b;
        bus1.start  = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        for (int e = 1; e <= 200; e++) begin
            @(posedge clk);
            #1;
            if (bus1.done === 1'b1) begin
                de = e;
                break;
            end
        end
        checks++; if (de != 150) begin errors++; $display("FAIL %s_latency: done at edge %0d want 150", name, de); end
        ex = sb1.pop_front();
        checks++; if (bus1.c_flat !== ex.c) begin errors++; $display("FAIL %s_c: got %h want %h", name, bus1.c_flat, ex.c); end
        checks++; if (bus1.is_identity !== ex.id) begin errors++; $display("FAIL %s_id_model: got %b want %b", name, bus1.is_identity, ex.id); end
        checks++; if (bus1.is_identity !== want_id) begin errors++; $display("FAIL %s_id: got %b want %b", name, bus1.is_identity, want_id); end
    endtask

    task automatic test_tolerance();
        run_tol(32'h0001_0001, 1'b1, "tol_in");
        run_tol(32'h0001_0003, 1'b0, "tol_out");
    endtask

    initial begin
        bus0.start  = 1'b0;
        bus0.a_flat = '0;
        bus0.b_flat = '0;
        bus1.start  = 1'b0;
        bus1.a_flat = '0;
        bus1.b_flat = '0;
        test_reset();
        test_identity();
        test_mul_identity();
        test_overflow();
        test_ignored_start_and_reset();
        test_tolerance();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
